// File: rtl/alu_op_decoder_if.sv
// Handshake bundle between instruction fetch, the op decoder and the ALU issue side.
interface alu_op_decoder_if #(
  parameter int CNT_W = 8
);
  logic             flush;
  logic             in_valid;
  logic [8:0]       inst;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       op_o;
  logic [3:0]       reg_o;
  logic             is_alu_o;
  logic             illegal_o;
  logic [CNT_W-1:0] illegal_cnt;

  // Fetch/issue side: drives instructions in and consumes decoded entries.
  modport master (
    output flush, in_valid, inst, out_ready,
    input  in_ready, out_valid, op_o, reg_o, is_alu_o, illegal_o, illegal_cnt
  );

  // Decoder side.
  modport slave (
    input  flush, in_valid, inst, out_ready,
    output in_ready, out_valid, op_o, reg_o, is_alu_o, illegal_o, illegal_cnt
  );
endinterface

// File: rtl/alu_op_decoder.sv
// Decode stage: turns 9-bit instruction words into ALU op codes, buffers up to
// two decoded entries in a skid FIFO and keeps a saturating illegal-op count.
module alu_op_decoder #(
  parameter int CNT_W = 8
) (
  input logic             Clk,
  input logic             Reset,
  alu_op_decoder_if.slave bus
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_LSH  = 4'd1,
    OP_RSH  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_AND  = 4'd5,
    OP_SUB  = 4'd6,
    OP_CLR  = 4'd7,
    OP_XORA = 4'd8
  } op_mne_e;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] rd;
    logic       is_alu;
    logic       illegal;
  } entry_t;

  // Undefined ALU op fields collapse to CLR so the ALU never sees an unknown code.
  function automatic entry_t decode(input logic [8:0] w);
    entry_t e;
    e.rd = w[3:0];
    if (w[8]) begin
      e.op      = OP_CLR;
      e.is_alu  = 1'b0;
      e.illegal = 1'b0;
    end else if (w[7:4] > 4'd8) begin
      e.op      = OP_CLR;
      e.is_alu  = 1'b1;
      e.illegal = 1'b1;
    end else begin
      e.op      = w[7:4];
      e.is_alu  = 1'b1;
      e.illegal = 1'b0;
    end
    return e;
  endfunction

  logic [1:0]       count_q, count_d;
  entry_t           head_q, head_d;
  entry_t           tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic   push;
  logic   pop;
  logic   out_valid;
  entry_t new_entry;

  // in_ready comes from occupancy only, so there is no ready path from the ALU side.
  assign bus.in_ready = (count_q != 2'd2);
  assign out_valid    = (count_q != 2'd0);
  assign bus.out_valid = out_valid;

  // A flushed push is dropped entirely, including from the illegal count.
  assign push      = bus.in_valid && bus.in_ready && !bus.flush;
  assign pop       = out_valid && bus.out_ready;
  assign new_entry = decode(bus.inst);

  // Head drives the outputs; an empty buffer presents zeros.
  assign bus.op_o        = out_valid ? head_q.op      : 4'd0;
  assign bus.reg_o       = out_valid ? head_q.rd      : 4'd0;
  assign bus.is_alu_o    = out_valid ? head_q.is_alu  : 1'b0;
  assign bus.illegal_o   = out_valid ? head_q.illegal : 1'b0;
  assign bus.illegal_cnt = cnt_q;

  // Next-state for the two-slot FIFO and the saturating illegal counter.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;

    if (bus.flush) begin
      count_d = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_d = new_entry;
          else                 tail_d = new_entry;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_d = new_entry;
          end else begin
            head_d = tail_q;
            tail_d = new_entry;
          end
        end
        default: begin
        end
      endcase
    end

    if (push && new_entry.illegal && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers, cleared asynchronously by Reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed, table-driven bench for alu_op_decoder.
module tb_alu_op_decoder;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  alu_op_decoder_if #(.CNT_W(8)) bus ();

  alu_op_decoder #(.CNT_W(8)) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       in_valid;
    logic [8:0] inst;
    logic       out_ready;
    logic       flush;
    logic       exp_valid;
    logic       exp_ready;
    logic [3:0] exp_op;
    logic [3:0] exp_reg;
    logic       exp_alu;
    logic       exp_ill;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic [8:0] i, input logic ordy,
                              input logic fl, input logic ev, input logic er,
                              input logic [3:0] eop, input logic [3:0] ereg,
                              input logic ealu, input logic eill, input logic [7:0] ecnt);
    vec_t r;
    r.in_valid = v;    r.inst = i;        r.out_ready = ordy; r.flush = fl;
    r.exp_valid = ev;  r.exp_ready = er;  r.exp_op = eop;     r.exp_reg = ereg;
    r.exp_alu = ealu;  r.exp_ill = eill;  r.exp_cnt = ecnt;
    return r;
  endfunction

  task automatic applyStimulus(input logic v, input logic [8:0] i, input logic ordy,
                               input logic fl);
    bus.in_valid  = v;
    bus.inst      = i;
    bus.out_ready = ordy;
    bus.flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic er,
                             input logic [3:0] eop, input logic [3:0] ereg,
                             input logic ealu, input logic eill, input logic [7:0] ecnt);
    check1({name, ".out_valid"},   int'(bus.out_valid),   int'(ev));
    check1({name, ".in_ready"},    int'(bus.in_ready),    int'(er));
    check1({name, ".op_o"},        int'(bus.op_o),        int'(eop));
    check1({name, ".reg_o"},       int'(bus.reg_o),       int'(ereg));
    check1({name, ".is_alu_o"},    int'(bus.is_alu_o),    int'(ealu));
    check1({name, ".illegal_o"},   int'(bus.illegal_o),   int'(eill));
    check1({name, ".illegal_cnt"}, int'(bus.illegal_cnt), int'(ecnt));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int exp_cnt;
    total = 0;
    bad   = 0;

    // Stream of single-cycle decodes with out_ready held high.
    vecs.push_back(mk(1, 9'b0_0000_0011, 1, 0, 1, 1, 4'd0, 4'd3, 1, 0, 8'd0));
    for (int op = 0; op <= 8; op++) begin
      logic [3:0] o;
      o = 4'(op);
      vecs.push_back(mk(1, {1'b0, o, o}, 1, 0, 1, 1, o, o, 1, 0, 8'd0));
    end
    vecs.push_back(mk(1, 9'b0_1100_0101, 1, 0, 1, 1, 4'd7, 4'd5,  1, 1, 8'd1));
    vecs.push_back(mk(1, 9'b1_0000_1010, 1, 0, 1, 1, 4'd7, 4'd10, 0, 0, 8'd1));
    vecs.push_back(mk(1, 9'b0_1001_0001, 1, 0, 1, 1, 4'd7, 4'd1,  1, 1, 8'd2));
    vecs.push_back(mk(1, 9'b1_1111_1111, 1, 0, 1, 1, 4'd7, 4'd15, 0, 0, 8'd2));
    vecs.push_back(mk(0, 9'd0,           1, 0, 0, 1, 4'd0, 4'd0,  0, 0, 8'd2));

    bus.in_valid  = 1'b0;
    bus.inst      = 9'd0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    reset         = 1'b1;
    #11;
    checkOutput("reset", 0, 1, 4'd0, 4'd0, 0, 0, 8'd0);
    #1 reset = 1'b0;

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].in_valid, vecs[k].inst, vecs[k].out_ready, vecs[k].flush);
      checkOutput($sformatf("vec%0d", k), vecs[k].exp_valid, vecs[k].exp_ready,
                  vecs[k].exp_op, vecs[k].exp_reg, vecs[k].exp_alu, vecs[k].exp_ill,
                  vecs[k].exp_cnt);
    end

    // Backpressure: A and B fill the buffer, C waits until a pop frees a slot.
    applyStimulus(1, 9'h011, 0, 0); checkOutput("fullA",   1, 1, 4'd1, 4'd1, 1, 0, 8'd2);
    applyStimulus(1, 9'h022, 0, 0); checkOutput("fullB",   1, 0, 4'd1, 4'd1, 1, 0, 8'd2);
    applyStimulus(1, 9'h033, 0, 0); checkOutput("fullC",   1, 0, 4'd1, 4'd1, 1, 0, 8'd2);
    applyStimulus(1, 9'h033, 1, 0); checkOutput("popA",    1, 1, 4'd2, 4'd2, 1, 0, 8'd2);
    applyStimulus(1, 9'h033, 0, 0); checkOutput("acceptC", 1, 0, 4'd2, 4'd2, 1, 0, 8'd2);
    applyStimulus(0, 9'd0,   1, 0); checkOutput("popB",    1, 1, 4'd3, 4'd3, 1, 0, 8'd2);
    applyStimulus(0, 9'd0,   1, 0); checkOutput("popC",    0, 1, 4'd0, 4'd0, 0, 0, 8'd2);

    // Flush with a full buffer, then flush with room so the illegal push is really dropped.
    applyStimulus(1, 9'h044, 0, 0); checkOutput("fl_fill1", 1, 1, 4'd4, 4'd4, 1, 0, 8'd2);
    applyStimulus(1, 9'h055, 0, 0); checkOutput("fl_fill2", 1, 0, 4'd4, 4'd4, 1, 0, 8'd2);
    applyStimulus(1, 9'h0F0, 1, 1); checkOutput("fl_full",  0, 1, 4'd0, 4'd0, 0, 0, 8'd2);
    applyStimulus(1, 9'h066, 0, 0); checkOutput("fl_one",   1, 1, 4'd6, 4'd6, 1, 0, 8'd2);
    applyStimulus(1, 9'h0C0, 0, 1); checkOutput("fl_drop",  0, 1, 4'd0, 4'd0, 0, 0, 8'd2);
    applyStimulus(1, 9'h056, 1, 0); checkOutput("fl_after", 1, 1, 4'd5, 4'd6, 1, 0, 8'd2);
    applyStimulus(0, 9'd0,   1, 0); checkOutput("fl_drain", 0, 1, 4'd0, 4'd0, 0, 0, 8'd2);

    // Counter saturation over 260 back-to-back illegal instructions.
    exp_cnt = 2;
    for (int k = 1; k <= 260; k++) begin
      applyStimulus(1, 9'b0_1010_0000, 1, 0);
      exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      checkOutput($sformatf("sat%0d", k), 1, 1, 4'd7, 4'd0, 1, 1, 8'(exp_cnt));
    end

    // Asynchronous reset mid-stream, checked between edges.
    #2 reset = 1'b1;
    #1 checkOutput("async_rst", 0, 1, 4'd0, 4'd0, 0, 0, 8'd0);
    #1 reset = 1'b0;
    applyStimulus(1, 9'b0_0111_0010, 1, 0);
    checkOutput("post_rst", 1, 1, 4'd7, 4'd2, 1, 0, 8'd0);
    applyStimulus(0, 9'd0, 1, 0);
    checkOutput("post_rst_drain", 0, 1, 4'd0, 4'd0, 0, 0, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_op_decoder.md
# alu_op_decoder

Front-end decode stage that turns 9-bit instruction words into ALU op codes of the shared `op_mne` type (ADD=0, LSH=1, RSH=2, OR=3, XOR=4, AND=5, SUB=6, CLR=7, XORA=8). It sits between instruction fetch and the ALU. It buffers up to two decoded instructions behind a valid/ready handshake on each side. It also flags and counts illegal op fields.

## Interface
- `CNT_W`, default 8: width of the saturating illegal-instruction counter.
- `Clk`  in  1  single clock; all state updates on rising edge.
- `Reset`  in  1  asynchronous, active-high; clears all state immediately.
- `flush`  in  1  synchronous; discards all buffered entries this cycle.
- `in_valid`  in  1  fetch presents `inst`.
- `inst`  in  9  instruction word.
- `in_ready`  out  1  decoder can accept; handshake when `in_valid && in_ready`.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  ALU/issue consumes head; handshake when `out_valid && out_ready`.
- `op_o`  out  4  `op_mne` code of head entry.
- `reg_o`  out  4  register field of head entry.
- `is_alu_o`  out  1  head is an ALU instruction.
- `illegal_o`  out  1  head had an undefined op field.
- `illegal_cnt`  out  CNT_W  count of accepted illegal instructions, saturating.

## Operation
- Decode is combinational on `inst` at accept time. The decoded tuple {op, reg, is_alu, illegal} is what gets stored.
- `inst[8]=0` selects an ALU instruction:
  - `op = inst[7:4]`, `reg = inst[3:0]`, `is_alu=1`.
  - If `inst[7:4]` > 8: `illegal=1`, `op` forced to CLR (7), `is_alu=1`.
- `inst[8]=1` selects a non-ALU instruction: `is_alu=0`, `op=CLR`, `reg=inst[3:0]`, `illegal=0`.
- Buffer is a 2-entry FIFO (skid) with occupancy 0/1/2. Order is preserved; the head drives all `*_o` outputs.
- `in_ready = (occupancy < 2)`. This is registered-state-derived only and never depends combinationally on `out_ready`.
- Push and pop in the same cycle leave occupancy unchanged. At occupancy 1, the new entry becomes head next cycle.
- `illegal_cnt` increments by 1 on every accepted instruction with `illegal=1` and holds at all-ones. It is not cleared by `flush`.
- Flush:
  - `flush=1` sets occupancy to 0 next cycle.
  - A push in the same cycle is dropped: it does not enter the buffer and does not count as illegal.
  - A pop in the same cycle is irrelevant.
- `out_valid=0`: `op_o`/`reg_o`/`is_alu_o`/`illegal_o` are don't-care for consumers, but the implementation drives 0.

## Timing
- Reset values: `out_valid=0`, `in_ready=1`, `op_o=0`, `reg_o=0`, `is_alu_o=0`, `illegal_o=0`, `illegal_cnt=0`, occupancy 0.
- Latency: an instruction accepted at edge N appears on outputs with `out_valid=1` after edge N when the buffer was empty. Minimum is 1 cycle; there is no combinational input-to-output path.
- Throughput: 1 instruction/cycle sustained while `out_ready=1`.
- Full: after 2 accepts with no pops, `in_ready=0` until a pop occurs. `in_ready` rises the cycle after the pop edge.
- `out_ready` low holds head outputs stable.
- `Reset` asserted mid-stream empties the buffer and clears the counter asynchronously. First accept is possible on the first edge after deassertion.

## Test plan
- Reset then `inst=9'b0_0000_0011` with `in_valid=1`, `out_ready=1` -> next cycle `out_valid=1`, `op_o=0` (ADD), `reg_o=3`, `is_alu_o=1`, `illegal_o=0`.
- Stream ops 0..8 (reg = op) back-to-back with `out_ready=1` -> outputs ADD..XORA in order, one per cycle, `in_ready` never drops.
- `inst=9'b0_1100_0101` (op 12) -> `op_o=7`, `illegal_o=1`, `illegal_cnt=1`; then `inst=9'b1_0000_1010` -> `is_alu_o=0`, `op_o=7`, `reg_o=10`, count stays 1.
- Hold `out_ready=0`, push 3 instructions -> third held, `in_ready=0` after 2 accepts. Raise `out_ready` for one cycle -> first popped, `in_ready=1` next cycle, third accepted, order A,B,C preserved.
- Fill 2 entries, assert `flush` together with a push of an illegal op -> next cycle `out_valid=0`, `in_ready=1`, `illegal_cnt` unchanged.
- Push 260 illegal instructions with `CNT_W=8` -> `illegal_cnt=255`; assert `Reset` mid-stream -> all outputs to reset values without waiting for an edge.
